easyaxi_wr_slv: RTL

EASYAXI_WR_SLV -- requirements
Module: easyaxi_wr_slv

---
 rtl/easyaxi_wr_slv.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/easyaxi_wr_slv.sv
// AXI write slave backed by a small word-addressed memory.
// Accepts one AW burst at a time, writes the W beats with byte strobes into
// memory, then answers with a single B response (OKAY or SLVERR).
//
// Handshake rule used on every channel: a transfer happens at the rising
// clock edge where both valid and ready are high. Ready/valid driven by this
// block depend only on the FSM state (and enable for AW), never on the
// partner's valid, so no combinational loop exists through the block.
module easyaxi_wr_slv #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       axi_slv_awvalid,
  output logic                       axi_slv_awready,
  input  logic [ID_W-1:0]            axi_slv_awid,
  input  logic [ADDR_W-1:0]          axi_slv_awaddr,
  input  logic [LEN_W-1:0]           axi_slv_awlen,
  input  logic [2:0]                 axi_slv_awsize,
  input  logic [1:0]                 axi_slv_awburst,
  input  logic                       axi_slv_wvalid,
  output logic                       axi_slv_wready,
  input  logic [DATA_W-1:0]          axi_slv_wdata,
  input  logic [DATA_W/8-1:0]        axi_slv_wstrb,
  input  logic                       axi_slv_wlast,
  output logic                       axi_slv_bvalid,
  input  logic                       axi_slv_bready,
  output logic [ID_W-1:0]            axi_slv_bid,
  output logic [1:0]                 axi_slv_bresp,
  input  logic [$clog2(DEPTH)-1:0]   dbg_idx,
  output logic [DATA_W-1:0]          dbg_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int SB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  // state_q is the FSM state; probe it hierarchically when debugging.
  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  // One bit wider than awlen so a 256-beat burst never wraps the count.
  logic [LEN_W:0]      cnt_q, cnt_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                aw_hs, w_hs;
  logic                bad_burst, bad_size, out_of_range, last_beat;
  logic                beat_drop, beat_err;
  logic [IW-1:0]       mem_idx;
  logic [ADDR_W-1:0]   addr_step;

  assign axi_slv_awready = (state_q == IDLE) && enable;
  assign axi_slv_wready  = (state_q == DATA);
  assign axi_slv_bvalid  = (state_q == RESP);
  assign axi_slv_bid     = id_q;
  assign axi_slv_bresp   = ((state_q == RESP) && err_q) ? 2'b10 : 2'b00;
  assign dbg_rdata       = mem[dbg_idx];

  assign aw_hs = axi_slv_awvalid && axi_slv_awready;
  assign w_hs  = axi_slv_wvalid && axi_slv_wready;

  // WRAP and the reserved encoding both have burst[1] set.
  assign bad_burst    = burst_q[1];
  assign bad_size     = size_q > 3'(SB);
  assign out_of_range = {1'b0, addr_q} >= MEM_BYTES;
  assign last_beat    = (cnt_q == {1'b0, len_q});
  assign beat_drop    = bad_burst || bad_size || out_of_range;
  // A misplaced or missing wlast is flagged but does not change the beat count.
  assign beat_err     = beat_drop || (axi_slv_wlast != last_beat);
  assign mem_idx      = addr_q[IW+SB-1:SB];
  assign addr_step    = ADDR_W'(1) << size_q;

  // Next-state and captured-field update for the AW/W/B sequence.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = axi_slv_awid;
          addr_d  = axi_slv_awaddr;
          len_d   = axi_slv_awlen;
          size_d  = axi_slv_awsize;
          burst_d = axi_slv_awburst;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + 1'b1;
          err_d = err_q || beat_err;
          if (burst_q == 2'b01) begin
            addr_d = addr_q + addr_step;
          end
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (axi_slv_bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and captured-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobed byte-lane writes; memory contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_hs && !beat_drop) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_slv_wstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= axi_slv_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
